// File: rtl/fwft_rr_read_scheduler_if.sv
// Bus bundle between the FWFT FIFO bank, the read scheduler and its consumer.
//   ch_enable   per-channel eligibility mask
//   fifo_empty  FWFT empty flag per channel
//   fifo_dout   FWFT head words, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_count  readable words per channel, packed like fifo_dout
//   fifo_rd_en  pop strobe, one-hot or zero
//   m_valid/m_ready/m_data/m_ch/m_last  registered output stream
//   busy        scheduler is mid-burst or holding an output word
// modport master: scheduler view; modport slave: FIFO bank + consumer view.
interface fwft_rr_read_scheduler_if #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 11
);
  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]            ch_enable;
  logic [NUM_CH-1:0]            fifo_empty;
  logic [NUM_CH*DATA_WIDTH-1:0] fifo_dout;
  logic [NUM_CH*CNT_WIDTH-1:0]  fifo_count;
  logic [NUM_CH-1:0]            fifo_rd_en;
  logic                         m_valid;
  logic                         m_ready;
  logic [DATA_WIDTH-1:0]        m_data;
  logic [CH_W-1:0]              m_ch;
  logic                         m_last;
  logic                         busy;

  modport master (
    input  ch_enable, fifo_empty, fifo_dout, fifo_count, m_ready,
    output fifo_rd_en, m_valid, m_data, m_ch, m_last, busy
  );

  modport slave (
    output ch_enable, fifo_empty, fifo_dout, fifo_count, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_ch, m_last, busy
  );
endinterface

// File: rtl/fwft_rr_read_scheduler.sv
// Round-robin read scheduler sharing one registered valid/ready stream among
// NUM_CH FWFT FIFO read sides. A grant is locked for min(count, BURST_LEN)
// words; the final word of each burst carries m_last.
//   rd_clk        sole clock, rising edge
//   global_rst_n  asynchronous active-low reset
//   bus           fwft_rr_read_scheduler_if.master (FIFO side + output stream)
module fwft_rr_read_scheduler #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 11,
  parameter int unsigned BURST_LEN  = 16
) (
  input  logic                     rd_clk,
  input  logic                     global_rst_n,
  fwft_rr_read_scheduler_if.master bus
);
  localparam int unsigned CH_W = $clog2(NUM_CH);
  localparam int unsigned BW   = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_WIDTH-1:0] BL_C = CNT_WIDTH'(BURST_LEN);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state, state_next;
  logic [CH_W-1:0]       last_grant, grant;
  logic [BW-1:0]         beat_cnt, burst_size;
  logic                  m_valid_q, m_last_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [CH_W-1:0]       m_ch_q;

  logic [NUM_CH-1:0]     elig;
  logic                  found;
  logic [CH_W-1:0]       pick, cand;
  logic [CNT_WIDTH-1:0]  pick_cnt;
  logic [BW-1:0]         size_pick;
  logic [DATA_WIDTH-1:0] head;
  logic                  pop, last_beat, load_grant;
  logic [NUM_CH-1:0]     rd_en;

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      elig[i] = bus.ch_enable[i] && !bus.fifo_empty[i] &&
                (bus.fifo_count[i*CNT_WIDTH +: CNT_WIDTH] != '0);
    end
  end

  // Scan starts one past the previous grant, so the last winner is checked last.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((32'(last_grant) + k) % NUM_CH);
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    pick_cnt  = bus.fifo_count[pick*CNT_WIDTH +: CNT_WIDTH];
    size_pick = (pick_cnt < BL_C) ? pick_cnt[BW-1:0] : BL_C[BW-1:0];
  end

  assign head      = bus.fifo_dout[grant*DATA_WIDTH +: DATA_WIDTH];
  assign last_beat = (beat_cnt == burst_size - BW'(1));

  always_ff @(posedge rd_clk or negedge global_rst_n) begin
    if (!global_rst_n) state <= IDLE;
    else               state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_grant = 1'b0;
    pop        = 1'b0;
    rd_en      = '0;
    case (state)
      IDLE: begin
        if (found) begin
          load_grant = 1'b1;
          state_next = BURST;
        end
      end
      BURST: begin
        pop         = !bus.fifo_empty[grant] && (!m_valid_q || bus.m_ready);
        rd_en[grant] = pop;
        if (pop && last_beat) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      last_grant <= CH_W'(NUM_CH - 1);
      grant      <= '0;
      beat_cnt   <= '0;
      burst_size <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_data_q   <= '0;
      m_ch_q     <= '0;
    end else begin
      if (load_grant) begin
        grant      <= pick;
        burst_size <= size_pick;
        beat_cnt   <= '0;
      end
      // A pop reloads the output register even when the consumer accepts
      // in the same cycle, giving back-to-back words.
      if (pop) begin
        m_data_q  <= head;
        m_ch_q    <= grant;
        m_valid_q <= 1'b1;
        m_last_q  <= last_beat;
        beat_cnt  <= beat_cnt + BW'(1);
        if (last_beat) last_grant <= grant;
      end else if (bus.m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;
  assign bus.m_ch       = m_ch_q;
  assign bus.m_last     = m_last_q;
  assign bus.busy       = (state == BURST) || m_valid_q;
endmodule

// File: tb/tb_fwft_rr_read_scheduler.sv
// Directed bench for fwft_rr_read_scheduler: queue-based FWFT FIFO models,
// an output stream recorder and hand-derived expected sequences.
module tb_fwft_rr_read_scheduler;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DW     = 64;
  localparam int unsigned CW     = 11;
  localparam int unsigned BL     = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fwft_rr_read_scheduler_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  fwft_rr_read_scheduler #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .BURST_LEN(BL)
  ) u_dut (
    .rd_clk(clk),
    .global_rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    ch;
    logic          last;
  } beat_t;

  logic [DW-1:0] q [NUM_CH][$];
  bit            hide [NUM_CH];
  int            stall_at [NUM_CH];
  int            popped [NUM_CH];
  int            pushed [NUM_CH];
  beat_t         rx [$];
  logic [NUM_CH-1:0] rd_seen;
  logic [NUM_CH-1:0] pend;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int ch, input int k);
    logic [7:0] h;
    h = 8'hC0 + 8'(ch);
    return {h, 56'(k)};
  endfunction

  task automatic update_fifo();
    for (int i = 0; i < NUM_CH; i++) begin
      bus.fifo_empty[i] = (q[i].size() == 0) || hide[i];
      bus.fifo_dout[i*DW +: DW] = (q[i].size() != 0) ? q[i][0] : '0;
      bus.fifo_count[i*CW +: CW] = CW'(q[i].size());
    end
  endtask

  task automatic push(input int ch, input int n);
    for (int j = 0; j < n; j++) begin
      q[ch].push_back(mk(ch, pushed[ch]));
      pushed[ch]++;
    end
    update_fifo();
  endtask

  // FIFO pops follow the strobe that was stable just before the edge.
  always begin
    @(negedge clk);
    pend = bus.fifo_rd_en;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pend[i] && q[i].size() != 0) begin
        void'(q[i].pop_front());
        popped[i]++;
        if (popped[i] == stall_at[i]) hide[i] = 1'b1;
      end
    end
    update_fifo();
  end

  always @(negedge clk) begin
    beat_t b;
    rd_seen = rd_seen | bus.fifo_rd_en;
    if (bus.m_valid && bus.m_ready) begin
      b.data = bus.m_data;
      b.ch   = bus.m_ch;
      b.last = bus.m_last;
      rx.push_back(b);
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      q[i].delete();
      hide[i]     = 1'b0;
      stall_at[i] = -1;
      popped[i]   = 0;
      pushed[i]   = 0;
    end
    rx.delete();
    rd_seen = '0;
    update_fifo();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (rx.size() < n && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    check(tag, 64'(rx.size() >= n), 64'd1);
  endtask

  task automatic wait_popped(input int ch, input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (popped[ch] < n && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    check(tag, 64'(popped[ch] >= n), 64'd1);
  endtask

  task automatic check_beat(input string tag, input int idx, input int ch, input int k, input bit last);
    if (idx >= rx.size()) begin
      check({tag, " missing"}, 64'(rx.size()), 64'(idx + 1));
    end else begin
      check({tag, " ch"},   64'(rx[idx].ch),   64'(ch));
      check({tag, " data"}, rx[idx].data,      mk(ch, k));
      check({tag, " last"}, 64'(rx[idx].last), 64'(last));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_rd [6];
    logic       exp_v  [6];
    int idx;

    rst_n = 1'b0;
    bus.ch_enable = '0;
    bus.m_ready   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      hide[i] = 1'b0; stall_at[i] = -1; popped[i] = 0; pushed[i] = 0;
    end
    rd_seen = '0;
    update_fifo();

    // Reset values
    @(negedge clk);
    check("rst rd_en",  64'(bus.fifo_rd_en), 64'd0);
    check("rst valid",  64'(bus.m_valid),    64'd0);
    check("rst data",   bus.m_data,          64'd0);
    check("rst ch",     64'(bus.m_ch),       64'd0);
    check("rst last",   64'(bus.m_last),     64'd0);
    check("rst busy",   64'(bus.busy),       64'd0);

    // Three words on ch0: one IDLE cycle, three pops, A/B/C with last on C
    apply_reset();
    bus.ch_enable = '1;
    bus.m_ready   = 1'b1;
    push(0, 3);
    exp_rd = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    exp_v  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("t1 rd_en c%0d", c), 64'(bus.fifo_rd_en), 64'(exp_rd[c]));
      check($sformatf("t1 valid c%0d", c), 64'(bus.m_valid), 64'(exp_v[c]));
      if (c >= 2 && c <= 4) begin
        check($sformatf("t1 data c%0d", c), bus.m_data, mk(0, c - 2));
        check($sformatf("t1 last c%0d", c), 64'(bus.m_last), 64'(c == 4));
        check($sformatf("t1 ch c%0d", c), 64'(bus.m_ch), 64'd0);
        check($sformatf("t1 busy c%0d", c), 64'(bus.busy), 64'd1);
      end
      if (c == 5) check("t1 busy end", 64'(bus.busy), 64'd0);
    end

    // Four channels of 20 words: 16-word round then 4-word round
    apply_reset();
    bus.ch_enable = '1;
    bus.m_ready   = 1'b1;
    for (int ch = 0; ch < 4; ch++) push(ch, 20);
    wait_rx(80, 400, "t2 done");
    repeat (5) @(posedge clk);
    check("t2 count", 64'(rx.size()), 64'd80);
    idx = 0;
    for (int ch = 0; ch < 4; ch++)
      for (int k = 0; k < 16; k++) begin
        check_beat($sformatf("t2 r0 ch%0d k%0d", ch, k), idx, ch, k, k == 15);
        idx++;
      end
    for (int ch = 0; ch < 4; ch++)
      for (int k = 16; k < 20; k++) begin
        check_beat($sformatf("t2 r1 ch%0d k%0d", ch, k), idx, ch, k, k == 19);
        idx++;
      end

    // Backpressure for 5 cycles mid-burst
    apply_reset();
    bus.ch_enable = '1;
    bus.m_ready   = 1'b1;
    push(0, 10);
    wait_rx(3, 50, "t3 first3");
    bus.m_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("t3 hold rd_en c%0d", c), 64'(bus.fifo_rd_en), 64'd0);
      check($sformatf("t3 hold valid c%0d", c), 64'(bus.m_valid), 64'd1);
      check($sformatf("t3 hold data c%0d", c), bus.m_data, mk(0, 3));
      check($sformatf("t3 hold last c%0d", c), 64'(bus.m_last), 64'd0);
    end
    @(posedge clk);
    #1 bus.m_ready = 1'b1;
    wait_rx(10, 50, "t3 done");
    repeat (5) @(posedge clk);
    check("t3 count", 64'(rx.size()), 64'd10);
    for (int k = 0; k < 10; k++) check_beat($sformatf("t3 k%0d", k), k, 0, k, k == 9);

    // Mask 1010: only ch1 and ch3, alternating
    apply_reset();
    bus.ch_enable = 4'b1010;
    bus.m_ready   = 1'b1;
    for (int ch = 0; ch < 4; ch++) push(ch, 20);
    wait_rx(40, 400, "t4 done");
    repeat (5) @(posedge clk);
    check("t4 count", 64'(rx.size()), 64'd40);
    idx = 0;
    for (int r = 0; r < 2; r++)
      for (int ch = 1; ch < 4; ch += 2)
        for (int k = r * 16; k < (r == 0 ? 16 : 20); k++) begin
          check_beat($sformatf("t4 r%0d ch%0d k%0d", r, ch, k), idx, ch, k, k == (r == 0 ? 15 : 19));
          idx++;
        end
    check("t4 ch0/ch2 never popped", 64'(rd_seen & 4'b0101), 64'd0);
    check("t4 ch0 left", 64'(q[0].size()), 64'd20);
    check("t4 ch2 left", 64'(q[2].size()), 64'd20);

    // Granted FIFO runs dry after 2 of 5 words
    apply_reset();
    bus.ch_enable = '1;
    bus.m_ready   = 1'b1;
    stall_at[0] = 2;
    push(0, 5);
    wait_popped(0, 2, 50, "t5 two pops");
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("t5 stall rd_en c%0d", c), 64'(bus.fifo_rd_en), 64'd0);
      check($sformatf("t5 stall busy c%0d", c), 64'(bus.busy), 64'd1);
    end
    @(posedge clk);
    #1;
    hide[0] = 1'b0;
    update_fifo();
    wait_rx(5, 50, "t5 done");
    repeat (5) @(posedge clk);
    check("t5 count", 64'(rx.size()), 64'd5);
    check("t5 popped", 64'(popped[0]), 64'd5);
    for (int k = 0; k < 5; k++) check_beat($sformatf("t5 k%0d", k), k, 0, k, k == 4);

    // Asynchronous reset during a ch2 burst
    apply_reset();
    bus.ch_enable = '1;
    bus.m_ready   = 1'b1;
    push(2, 20);
    wait_popped(2, 5, 50, "t6 ch2 running");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6 arst rd_en", 64'(bus.fifo_rd_en), 64'd0);
    check("t6 arst valid", 64'(bus.m_valid),    64'd0);
    check("t6 arst data",  bus.m_data,          64'd0);
    check("t6 arst ch",    64'(bus.m_ch),       64'd0);
    check("t6 arst last",  64'(bus.m_last),     64'd0);
    check("t6 arst busy",  64'(bus.busy),       64'd0);
    rx.delete();
    push(0, 3);
    push(1, 3);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_rx(4, 50, "t6 after release");
    for (int k = 0; k < 3; k++) check_beat($sformatf("t6 ch0 k%0d", k), k, 0, k, k == 2);
    check_beat("t6 ch1 k0", 3, 1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fwft_rr_read_scheduler.md
# fwft_rr_read_scheduler

Round-robin read scheduler that shares one downstream stream port among NUM_CH first-word-fall-through FIFO read sides in the rd_clk domain. It picks a non-empty, enabled channel and locks the grant for a burst of min(occupancy, BURST_LEN) words. It pops the FIFO and drives the words through a registered valid/ready output with an end-of-burst marker. It sits between the FWFT FIFO bank and a single consumer such as a DMA or packer.

## Interface
- NUM_CH, 4, number of FIFO channels (2..16)
- DATA_WIDTH, 64, FIFO/output word width
- CNT_WIDTH, 11, width of each FIFO occupancy count (clogb2(1024))
- BURST_LEN, 16, maximum words per grant (1..2**(CNT_WIDTH-1))
- rd_clk  in  1  sole clock, rising edge
- global_rst_n  in  1  asynchronous, active-low reset
- ch_enable  in  NUM_CH  per-channel eligibility mask; sampled only at grant decision
- fifo_empty  in  NUM_CH  FWFT empty per channel
- fifo_dout  in  NUM_CH*DATA_WIDTH  FWFT head words; channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- fifo_count  in  NUM_CH*CNT_WIDTH  readable words per channel (elements_rd), packed the same way
- fifo_rd_en  out  NUM_CH  pop strobe; one-hot or zero
- m_valid  out  1  output word valid
- m_ready  in  1  consumer accepts the word when m_valid&&m_ready
- m_data  out  DATA_WIDTH  output word
- m_ch  out  clog2(NUM_CH)  source channel of m_data
- m_last  out  1  final word of the current burst
- busy  out  1  high while in BURST or while m_valid is high

## Operation
- FSM states: IDLE, BURST.
- Eligibility: channel i is eligible when ch_enable[i] && !fifo_empty[i] && fifo_count[i]!=0.
- IDLE:
  - Search from last_grant+1 upward, wrapping modulo NUM_CH, for the first eligible channel.
  - If one is found: grant <= i, burst_size <= min(fifo_count[i], BURST_LEN), beat_cnt <= 0, go to BURST.
  - No pop occurs in IDLE.
- BURST:
  - pop = !fifo_empty[grant] && (!m_valid || m_ready).
  - fifo_rd_en[grant] = pop, combinational from registered state and inputs; every other bit is 0.
  - On each pop, the head word is latched into m_data, m_ch <= grant, m_valid <= 1, beat_cnt <= beat_cnt+1.
  - m_last <= (beat_cnt == burst_size-1) on that word.
  - The pop with beat_cnt==burst_size-1 sets last_grant <= grant and returns to IDLE.
- Stall: fifo_empty[grant] high during BURST inserts no pop and holds state. The burst is never abandoned early.
- Output register: m_valid clears on m_valid&&m_ready with no same-cycle pop. With a same-cycle pop it reloads, giving back-to-back words.
- Backpressure: while m_valid&&!m_ready, m_data, m_ch and m_last hold stable and fifo_rd_en=0.
- ch_enable changes during BURST do not affect the current burst.
- Widths: beat_cnt and burst_size are clog2(BURST_LEN)+1 bits. The min() compare is unsigned at CNT_WIDTH.

## Timing
- Reset, asynchronous: state=IDLE, last_grant=NUM_CH-1 (channel 0 wins first), grant=0, beat_cnt=0. Outputs: fifo_rd_en=0, m_valid=0, m_data=0, m_ch=0, m_last=0, busy=0.
- Grant latency: one IDLE cycle after an eligible channel appears. The first pop is in the next cycle, and m_valid rises one cycle after the pop.
- Throughput: one word per cycle within a burst when m_ready=1 and the FIFO stays non-empty.
- Burst turnaround: one IDLE bubble cycle on fifo_rd_en between bursts. m_valid may stay high across it if the consumer stalls.
- Reset deassertion mid-burst: resumes at IDLE from channel 0. Words already popped are lost; the spec accepts this.
- Simultaneous last pop and consumer accept: both take effect; m_valid stays high with the last word.

## Test plan
- Reset then ch0 holds 3 words A,B,C, m_ready=1:
  - IDLE 1 cycle, then fifo_rd_en[0] high for 3 cycles.
  - m_data A,B,C on consecutive cycles, m_last only with C, m_ch=0.
  - busy low after C is accepted.
- All 4 channels count=20, BURST_LEN=16:
  - Grants run ch0,ch1,ch2,ch3 with 16 words each, then ch0,ch1,ch2,ch3 with 4 words each (wrap-around).
  - m_last on every 16th word of the first round and every 4th word of the second.
- m_ready held low 5 cycles mid-burst:
  - m_data and m_last stable, fifo_rd_en=0 throughout.
  - After release, no word is dropped or duplicated; beat count is exact.
- ch_enable=4'b1010, all FIFOs non-empty: only ch1 and ch3 are granted, alternating; ch0 and ch2 never pop.
- Granted channel goes empty after 2 of 5 words: FSM holds BURST with no pop; on refill, the remaining 3 words issue and m_last lands on the 5th.
- global_rst_n pulsed low during ch2 burst:
  - All outputs go to 0 immediately (asynchronously).
  - After release, the first grant is the lowest eligible channel starting from ch0.
